// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
//  Module   : instr_fetch_ctrl
//  Function : Byte-serial instruction fetch with a program-loader write port.
//             Four byte reads are assembled big-endian into one 32-bit word.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_AW   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              ld_req,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_gnt,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        issued_all, issued_all_nxt;
    logic        rd_pend, rd_pend_nxt;
    logic [1:0]  rd_k, rd_k_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] instr_pc_nxt;
    logic        instr_valid_nxt;
    logic        rd_issue;
    logic        accept;

    // cnt wraps after the fourth read; issued_all stops further reads until
    // the last byte lands and the FSM moves to HOLD.
    assign rd_issue = (state == ST_ISSUE) && !ld_req && !issued_all;
    assign accept   = instr_valid && instr_ready;

    // Memory-side outputs are combinational; forced quiet while in reset.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        ld_gnt    = 1'b0;
        mem_wdata = 8'h00;
        mem_addr  = '0;
        if (rst_n) begin
            if (ld_req) begin
                ld_gnt    = 1'b1;
                mem_wr_en = 1'b1;
                mem_wdata = ld_data;
                mem_addr  = ld_addr;
            end else begin
                mem_rd_en = rd_issue;
                mem_addr  = fetch_pc[MEM_AW-1:0] + MEM_AW'(cnt);
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        cnt_nxt         = cnt;
        issued_all_nxt  = issued_all;
        rd_pend_nxt     = 1'b0;
        rd_k_nxt        = rd_k;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;

        if (rd_issue) begin
            rd_pend_nxt = 1'b1;
            rd_k_nxt    = cnt;
            cnt_nxt     = cnt + 2'd1;
            if (cnt == 2'd3) begin
                issued_all_nxt = 1'b1;
            end
        end

        if (rd_pend) begin
            case (rd_k)
                2'd0:    instr_nxt[31:24] = mem_rdata;
                2'd1:    instr_nxt[23:16] = mem_rdata;
                2'd2:    instr_nxt[15:8]  = mem_rdata;
                default: instr_nxt[7:0]   = mem_rdata;
            endcase
            if (rd_k == 2'd3) begin
                instr_valid_nxt = 1'b1;
                instr_pc_nxt    = fetch_pc;
                state_nxt       = ST_HOLD;
            end
        end

        if (accept) begin
            instr_valid_nxt = 1'b0;
            fetch_pc_nxt    = fetch_pc + 32'd4;
            cnt_nxt         = 2'd0;
            issued_all_nxt  = 1'b0;
            state_nxt       = ST_ISSUE;
        end

        // Redirect overrides everything, including a same-cycle accept and
        // the byte still in flight from this cycle's read.
        if (redirect_valid) begin
            fetch_pc_nxt    = redirect_pc;
            cnt_nxt         = 2'd0;
            issued_all_nxt  = 1'b0;
            rd_pend_nxt     = 1'b0;
            instr_nxt       = 32'h0;
            instr_valid_nxt = 1'b0;
            state_nxt       = ST_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ISSUE;
            fetch_pc    <= RESET_PC;
            cnt         <= 2'd0;
            issued_all  <= 1'b0;
            rd_pend     <= 1'b0;
            rd_k        <= 2'd0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            cnt         <= cnt_nxt;
            issued_all  <= issued_all_nxt;
            rd_pend     <= rd_pend_nxt;
            rd_k        <= rd_k_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================================
//  Module   : tb_instr_fetch_ctrl
//  Function : Directed self-checking bench for instr_fetch_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [11:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        ld_req;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_gnt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [7:0]  mem [0:4095];
    int          checks = 0;
    int          errors = 0;

    instr_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MEM_AW   (12)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_gnt         (ld_gnt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ld_req         = 1'b0;
        ld_addr        = 12'h000;
        ld_data        = 8'h00;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
    endtask

    // Leaves the caller at the start of cycle 0 (first cycle out of reset).
    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        rst_n   = 1'b0;
        ld_req  = 1'b1;
        ld_addr = 12'h5A5;
        ld_data = 8'hC3;
        #1;
        checks++;
        if ({mem_rd_en, mem_wr_en, ld_gnt, instr_valid, instr, instr_pc, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b wr=%b gnt=%b v=%b instr=%h pc=%h addr=%h wd=%h, all required 0",
                     mem_rd_en, mem_wr_en, ld_gnt, instr_valid, instr, instr_pc, mem_addr, mem_wdata);
        end
        tick();
        ld_req = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL reset_release_fetch: rd=%b addr=%h, required rd=1 addr=000", mem_rd_en, mem_addr);
        end
    endtask

    task automatic test_basic_fetch();
        apply_reset();
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) tick();
            instr_ready = 1'b1;
            #1;
            checks++;
            if (c < 4 || c == 6) begin
                if (mem_rd_en !== 1'b1 || mem_addr !== ((c == 6) ? 12'd4 : 12'(c))) begin
                    errors++;
                    $display("FAIL basic_read c=%0d: rd=%b addr=%h", c, mem_rd_en, mem_addr);
                end
            end else if (mem_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL basic_noread c=%0d: rd=%b, required 0", c, mem_rd_en);
            end
            checks++;
            if (instr_valid !== (c == 5)) begin
                errors++;
                $display("FAIL basic_valid c=%0d: valid=%b required %b", c, instr_valid, (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (instr !== 32'h1234_5678 || instr_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL basic_instr: instr=%h pc=%h, required 12345678 / 0", instr, instr_pc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) tick();
            redirect_valid = (c == 0);
            redirect_pc    = 32'h4;
            instr_ready    = (c == 16 || c == 22);
            #1;
            if (c >= 6 && c <= 16) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'h9ABC_DEF0 || instr_pc !== 32'h4 || mem_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d: v=%b instr=%h pc=%h rd=%b, required 1/9abcdef0/4/0",
                             c, instr_valid, instr, instr_pc, mem_rd_en);
                end
            end
            if (c == 17) begin
                checks++;
                if (instr_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 12'h008) begin
                    errors++;
                    $display("FAIL bp_after_accept: v=%b rd=%b addr=%h, required 0/1/008", instr_valid, mem_rd_en, mem_addr);
                end
            end
            if (c == 22) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'h0123_4567 || instr_pc !== 32'h8) begin
                    errors++;
                    $display("FAIL bp_next_instr: v=%b instr=%h pc=%h, required 1/01234567/8", instr_valid, instr, instr_pc);
                end
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            redirect_valid = (c == 3);
            redirect_pc    = 32'h100;
            instr_ready    = 1'b1;
            #1;
            if (c < 9) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_partial_valid c=%0d: valid=%b required 0", c, instr_valid);
                end
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (mem_rd_en !== 1'b1 || mem_addr !== 12'(12'h100 + c - 4)) begin
                    errors++;
                    $display("FAIL redir_read c=%0d: rd=%b addr=%h", c, mem_rd_en, mem_addr);
                end
            end
            if (c == 9) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'hAABB_CCDD || instr_pc !== 32'h100) begin
                    errors++;
                    $display("FAIL redir_instr: v=%b instr=%h pc=%h, required 1/aabbccdd/100", instr_valid, instr, instr_pc);
                end
            end
        end
    endtask

    task automatic test_loader_stall();
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            ld_req      = (c >= 1 && c <= 3);
            ld_addr     = 12'(12'h200 + c - 1);
            ld_data     = 8'(8'hE0 + c);
            instr_ready = 1'b1;
            #1;
            if (c >= 1 && c <= 3) begin
                checks++;
                if (ld_gnt !== 1'b1 || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 ||
                    mem_addr !== 12'(12'h200 + c - 1) || mem_wdata !== 8'(8'hE0 + c)) begin
                    errors++;
                    $display("FAIL ld_grant c=%0d: gnt=%b wr=%b rd=%b addr=%h wd=%h", c, ld_gnt, mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
                end
            end else begin
                checks++;
                if (ld_gnt !== 1'b0 || mem_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL ld_idle c=%0d: gnt=%b wr=%b, required 0/0", c, ld_gnt, mem_wr_en);
                end
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (mem_rd_en !== 1'b1 || mem_addr !== 12'(c - 3)) begin
                    errors++;
                    $display("FAIL ld_resume c=%0d: rd=%b addr=%h", c, mem_rd_en, mem_addr);
                end
            end
            if (c >= 7) begin
                checks++;
                if (instr_valid !== (c == 8)) begin
                    errors++;
                    $display("FAIL ld_valid_delay c=%0d: valid=%b required %b", c, instr_valid, (c == 8));
                end
            end
            if (c == 8) begin
                checks++;
                if (instr !== 32'h1234_5678 || instr_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL ld_instr: instr=%h pc=%h, required 12345678/0", instr, instr_pc);
                end
            end
        end
        ld_req = 1'b0;
        checks++;
        if ({mem[12'h200], mem[12'h201], mem[12'h202]} !== 24'hE1E2E3) begin
            errors++;
            $display("FAIL ld_written: %h %h %h, required e1 e2 e3", mem[12'h200], mem[12'h201], mem[12'h202]);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_addr [0:3];
        exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
        apply_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) tick();
            redirect_valid = (c == 0);
            redirect_pc    = 32'h0000_0FFE;
            instr_ready    = 1'b1;
            #1;
            if (c >= 1 && c <= 4) begin
                checks++;
                if (mem_rd_en !== 1'b1 || mem_addr !== exp_addr[c-1]) begin
                    errors++;
                    $display("FAIL wrap_addr c=%0d: rd=%b addr=%h required %h", c, mem_rd_en, mem_addr, exp_addr[c-1]);
                end
            end
            if (c >= 7 && c <= 10) begin
                checks++;
                if (mem_rd_en !== 1'b1 || mem_addr !== 12'(c - 5)) begin
                    errors++;
                    $display("FAIL wrap_next_addr c=%0d: rd=%b addr=%h", c, mem_rd_en, mem_addr);
                end
            end
            if (c == 6) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'h1122_1234 || instr_pc !== 32'hFFE) begin
                    errors++;
                    $display("FAIL wrap_instr: v=%b instr=%h pc=%h, required 1/11221234/ffe", instr_valid, instr, instr_pc);
                end
            end
            if (c == 12) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'h5678_9ABC || instr_pc !== 32'h1002) begin
                    errors++;
                    $display("FAIL wrap_next_instr: v=%b instr=%h pc=%h, required 1/56789abc/1002", instr_valid, instr, instr_pc);
                end
            end
        end
    endtask

    task automatic test_reset_midfetch();
        apply_reset();
        instr_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 12'h002) begin
            errors++;
            $display("FAIL midrst_pre: rd=%b addr=%h, required 1/002", mem_rd_en, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, mem_wr_en, ld_gnt, instr_valid, instr, instr_pc, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: rd=%b wr=%b gnt=%b v=%b instr=%h pc=%h addr=%h, all required 0",
                     mem_rd_en, mem_wr_en, ld_gnt, instr_valid, instr, instr_pc, mem_addr);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) tick();
            #1;
            if (c < 4) begin
                checks++;
                if (mem_rd_en !== 1'b1 || mem_addr !== 12'(c)) begin
                    errors++;
                    $display("FAIL midrst_restart c=%0d: rd=%b addr=%h", c, mem_rd_en, mem_addr);
                end
            end
            if (c == 5) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || instr_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL midrst_instr: v=%b instr=%h pc=%h, required 1/12345678/0", instr_valid, instr, instr_pc);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[0]      = 8'h12; mem[1]      = 8'h34; mem[2]      = 8'h56; mem[3]      = 8'h78;
        mem[4]      = 8'h9A; mem[5]      = 8'hBC; mem[6]      = 8'hDE; mem[7]      = 8'hF0;
        mem[8]      = 8'h01; mem[9]      = 8'h23; mem[10]     = 8'h45; mem[11]     = 8'h67;
        mem[12'h100] = 8'hAA; mem[12'h101] = 8'hBB; mem[12'h102] = 8'hCC; mem[12'h103] = 8'hDD;
        mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22;
        mem_rdata = 8'h00;
        rst_n     = 1'b0;
        idle_inputs();

        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect();
        test_loader_stall();
        test_wrap();
        test_reset_midfetch();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
